// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential rotate unit.
// SEQ_ROR_STEP4_EN selects a maximum rotate step of 4 instead of 1.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROTATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Width of the per-cycle step amount (0..4).
    localparam int STEP_W = 3;

`ifdef SEQ_ROR_STEP4_EN
    localparam int unsigned MAX_STEP = 4;
`else
    localparam int unsigned MAX_STEP = 1;
`endif

endpackage

// File: rtl/ror_step.sv
// Combinational rotate right of a WIDTH-bit value by 0..4 positions.
module ror_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]  data_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [WIDTH-1:0]  data_o
);

    always_comb begin
        case (step_i)
            3'd1:    data_o = {data_i[0],   data_i[WIDTH-1:1]};
            3'd2:    data_o = {data_i[1:0], data_i[WIDTH-1:2]};
            3'd3:    data_o = {data_i[2:0], data_i[WIDTH-1:3]};
            3'd4:    data_o = {data_i[3:0], data_i[WIDTH-1:4]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/seq_ror.sv
// seq_ror: multi-cycle rotate-right unit (IDLE/LOAD/ROTATE/DONE).
// Define SEQ_ROR_STEP4_EN to rotate up to four bits per ROTATE cycle.
module seq_ror
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Zlow,
    output logic [WIDTH-1:0] Zhigh
);

    localparam int CW = $clog2(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  zlow_q, zlow_d;
    logic [WIDTH-1:0]  rot_val;
    logic [CW-1:0]     count_next;
    logic [STEP_W-1:0] step;
    logic              accept;
    logic              y_unused;

    // Only y mod WIDTH matters; the upper bits are deliberately dropped.
    assign y_unused   = ^y[WIDTH-1:CW];
    assign accept     = start && (state_q == IDLE || state_q == DONE);
    assign step       = (count_q >= CW'(MAX_STEP)) ? STEP_W'(MAX_STEP) : STEP_W'(count_q);
    assign count_next = count_q - CW'(step);

    ror_step #(.WIDTH(WIDTH)) u_ror_step (
        .data_i (work_q),
        .step_i (step),
        .data_o (rot_val)
    );

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: default assignment first keeps the combinational block latch-free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = (count_q != '0) ? ROTATE : DONE;
            ROTATE:  if (count_next == '0) state_d = DONE;
            DONE:    state_d = accept ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == LOAD) || (state_q == ROTATE);
        done = (state_q == DONE);
    end

    always_comb begin
        work_d  = work_q;
        count_d = count_q;
        if (accept) begin
            work_d  = x;
            count_d = y[CW-1:0];
        end else if (state_q == ROTATE) begin
            work_d  = rot_val;
            count_d = count_next;
        end
        // Result register only loads on the edge that enters DONE.
        zlow_d = (state_d == DONE && state_q != DONE) ? work_d : zlow_q;
    end

    // NOTE: all datapath registers are cleared so an aborted operation leaves no stale result.
    always_ff @(posedge clock) begin
        if (reset) begin
            work_q  <= '0;
            count_q <= '0;
            zlow_q  <= '0;
        end else begin
            work_q  <= work_d;
            count_q <= count_d;
            zlow_q  <= zlow_d;
        end
    end

    assign Zlow  = zlow_q;
    assign Zhigh = '0;

endmodule

// File: tb/tb_seq_ror.sv
// Directed self-checking bench for seq_ror (WIDTH=32), with or without SEQ_ROR_STEP4_EN.
module tb_seq_ror;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] xv;
        logic [31:0] yv;
        logic [31:0] zv;
        bit          mid;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] zlow;
    logic [31:0] zhigh;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs [0:13] = '{
        '{32'h5555_5555, 32'd7,  32'hAAAA_AAAA, 1'b0},
        '{32'h0000_FFFF, 32'd7,  32'hFE00_01FF, 1'b1},
        '{32'h0000_0001, 32'd1,  32'h8000_0000, 1'b0},
        '{32'hAAAA_AAAA, 32'd32, 32'hAAAA_AAAA, 1'b0},
        '{32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0},
        '{32'hDEAD_BEEF, 32'd16, 32'hBEEF_DEAD, 1'b0},
        '{32'h1234_5678, 32'd8,  32'h7812_3456, 1'b0},
        '{32'h0000_0003, 32'd33, 32'h8000_0001, 1'b0},
        '{32'hF000_0000, 32'd5,  32'h0780_0000, 1'b0},
        '{32'h0000_0010, 32'd3,  32'h0000_0002, 1'b0},
        '{32'hFFFF_FFFF, 32'd13, 32'hFFFF_FFFF, 1'b0},
        '{32'h0000_000F, 32'd2,  32'hC000_0003, 1'b0},
        '{32'h8765_4321, 32'd12, 32'h3218_7654, 1'b0},
        '{32'h0000_0100, 32'd64, 32'h0000_0100, 1'b0}
    };

    seq_ror #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .Zlow  (zlow),
        .Zhigh (zhigh)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Latency = index of the rising edge (start-sampling edge = 0) that first samples done=1.
    function automatic int exp_lat(input int n);
        if (n == 0) return 2;
`ifdef SEQ_ROR_STEP4_EN
        return (n + 3) / 4 + 2;
`else
        return n + 2;
`endif
    endfunction

    // Called just after the start-sampling edge; returns once done is seen or the budget runs out.
    task automatic wait_done(input string tag, input logic [31:0] expz, input int lat, input bit mid);
        int  k    = 0;
        bit  seen = 1'b0;
        while (!seen && k < 200) begin
            tick();
            k++;
            if (mid && k == 2) begin
                check({tag, "_busy_mid"}, {31'b0, busy}, 32'd1);
                start = 1'b1;
                x     = 32'hFFFF_FFFF;
                y     = 32'd1;
            end else if (mid && k == 3) begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({tag, "_latency"}, k + 1, lat);
        check({tag, "_zlow"}, zlow, expz);
        check({tag, "_zhigh"}, zhigh, 32'h0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                          input logic [31:0] expz, input bit mid);
        start = 1'b1;
        x     = xv;
        y     = yv;
        tick();
        // Scramble operands right after acceptance; they must not leak in.
        start = 1'b0;
        x     = ~xv;
        y     = yv + 32'd5;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_done(tag, expz, exp_lat(int'(yv[4:0])), mid);
        tick();
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "_hold"}, zlow, expz);
    endtask

    initial begin
        int quiet_done;

        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        tick();
        tick();
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);
        check("rst_zlow",  zlow,  32'h0);
        check("rst_zhigh", zhigh, 32'h0);
        reset = 1'b0;
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].xv, vecs[i].yv, vecs[i].zv, vecs[i].mid);
        end

        // Back-to-back: start stays high through DONE so DONE goes straight to LOAD.
        start = 1'b1;
        x     = 32'h1234_5678;
        y     = 32'd4;
        tick();
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done("b2b_first", 32'h8123_4567, exp_lat(4), 1'b0);
        x = 32'h0000_000F;
        y = 32'd2;
        tick();
        check("b2b_no_idle_busy", {31'b0, busy}, 32'd1);
        check("b2b_no_idle_done", {31'b0, done}, 32'd0);
        start = 1'b0;
        x     = '0;
        y     = '0;
        wait_done("b2b_second", 32'hC000_0003, exp_lat(2), 1'b0);
        tick();

        // Abort in the third ROTATE cycle of a y=20 operation.
        start = 1'b1;
        x     = 32'h0F0F_0F0F;
        y     = 32'd20;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_zlow", zlow, 32'h0);
        reset      = 1'b0;
        quiet_done = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) quiet_done++;
        end
        check("abort_no_done", quiet_done, 0);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        x     = 32'h0000_00F0;
        y     = 32'd4;
        tick();
        check("prio_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("prio_still_idle", {31'b0, busy}, 32'd0);
        check("prio_zlow", zlow, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
